// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that shares one FIFO write port among NUM_REQ
// producers. The FIFO write is driven combinationally from the winner, the
// winner gets a registered one-cycle ack, and the FIFO's own w_ack is
// cross-checked against the write issued on the previous cycle.
module fifo_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ack,
  output logic                     o_w_e,
  output logic [WIDTH-1:0]         o_w_data,
  input  logic                     i_w_avail,
  input  logic                     i_w_ack,
  input  logic                     i_flush,
  output logic [ID_W-1:0]          o_grant_id,
  output logic                     o_err
);

  // Round-robin start index and the requester written on the previous cycle.
  // The previous winner is masked out because its i_req is still high while
  // it waits to see its ack.
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] busy_p1;
  logic               owner_v_p1;

  logic [NUM_REQ-1:0] elig;
  logic               issue;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    ptr_nxt;
  int                 idx;

  // Stage p0: pick the first eligible requester at or after ptr, wrapping.
  always_comb begin
    elig   = i_req & ~busy_p1;
    issue  = (|elig) & i_w_avail & ~i_flush;
    win    = '0;
    idx    = 0;
    // Scan from the farthest offset down so the nearest eligible one wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[ID_W'(idx)]) win = ID_W'(idx);
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    ptr_nxt     = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Drive the FIFO write port; all fields are zero when nothing is issued.
  always_comb begin
    o_w_e      = issue;
    o_w_data   = '0;
    o_grant_id = '0;
    if (issue) begin
      o_w_data   = i_req_data[int'(win)*WIDTH +: WIDTH];
      o_grant_id = win;
    end
  end

  // Stage p1: advance fairness pointer, ack the winner, check the FIFO ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr        <= '0;
      busy_p1    <= '0;
      owner_v_p1 <= 1'b0;
      o_req_ack  <= '0;
      o_err      <= 1'b0;
    end else begin
      // ptr only moves on a real write, so a full FIFO or a flush keeps the
      // same requester first in line.
      if (issue) ptr <= ptr_nxt;
      busy_p1    <= issue ? win_oh : '0;
      o_req_ack  <= issue ? win_oh : '0;
      owner_v_p1 <= issue;
      // The FIFO acks exactly the writes issued one cycle earlier; any
      // disagreement latches until reset.
      if (i_w_ack != owner_v_p1) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized
// traffic compared against a behavioural round-robin reference model.
module tb_fifo_wr_arb;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     ack;
  logic             w_e;
  logic [W-1:0]     w_data;
  logic             w_avail;
  logic             w_ack;
  logic             flush;
  logic [IDW-1:0]   gid;
  logic             err;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_req_ack(ack), .o_w_e(w_e), .o_w_data(w_data), .i_w_avail(w_avail),
    .i_w_ack(w_ack), .i_flush(flush), .o_grant_id(gid), .o_err(err)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state: integers, -1 meaning "none".
  int   m_ptr = 0, m_busy = -1, m_ack = -1;
  bit   m_owner = 1'b0, m_err = 1'b0;
  int   cnt = 0, depth = 2;
  bit   fifo_mode = 1'b0, avail_bit = 1'b1;
  int   exp_k = -1;
  logic rd_now = 1'b0;

  function automatic int model_win(logic [N-1:0] r, logic av, logic fl);
    if (!av || fl) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (r[k] && k != m_busy) return k;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_data();
    if (exp_k < 0) return '0;
    return req_data[exp_k*W +: W];
  endfunction

  function automatic logic [IDW-1:0] exp_gid();
    return (exp_k < 0) ? '0 : IDW'(exp_k);
  endfunction

  function automatic logic [N-1:0] exp_ackv();
    return (m_ack < 0) ? '0 : (N'(1) << m_ack);
  endfunction

  // Apply inputs just after an edge and let the combinational outputs settle.
  task automatic drive(input logic [N-1:0] r, input logic fl, input logic rd,
                       input logic bad, input logic rs);
    req     = r;
    flush   = fl;
    rd_now  = rd;
    rst     = rs;
    w_ack   = m_owner ^ bad;
    w_avail = fifo_mode ? (cnt < depth) : avail_bit;
    exp_k   = model_win(r, w_avail, fl);
    #1;
  endtask

  // Advance one clock and update the model with what the inputs implied.
  task automatic clock();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_busy = -1; m_ack = -1; m_owner = 1'b0; m_err = 1'b0; cnt = 0;
    end else begin
      if (w_ack != m_owner) m_err = 1'b1;
      if (exp_k >= 0) begin
        m_ptr = (exp_k + 1) % N; m_busy = exp_k; m_ack = exp_k; m_owner = 1'b1;
      end else begin
        m_busy = -1; m_ack = -1; m_owner = 1'b0;
      end
      if (flush) cnt = 0;
      else cnt = cnt + ((exp_k >= 0) ? 1 : 0) - ((rd_now && cnt > 0) ? 1 : 0);
    end
    #1;
  endtask

  task automatic do_reset();
    fifo_mode = 1'b0; avail_bit = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    clock();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (ack !== '0) begin nerr++; $display("FAIL reset_ack got %b want 0000", ack); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err); end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b0) begin nerr++; $display("FAIL reset_w_e got %b want 0", w_e); end
    nvec++; if (gid !== '0) begin nerr++; $display("FAIL reset_gid got %0d want 0", gid); end
    nvec++; if (w_data !== '0) begin nerr++; $display("FAIL reset_data got %h want 0", w_data); end
    clock();
  endtask

  task automatic test_single_write();
    do_reset();
    req_data = '0;
    req_data[31:0] = 32'hA5;
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b1) begin nerr++; $display("FAIL single_w_e got %b want 1", w_e); end
    nvec++; if (w_data !== 32'hA5) begin nerr++; $display("FAIL single_data got %h want a5", w_data); end
    clock();
    nvec++; if (ack !== 4'b0001) begin nerr++; $display("FAIL single_ack got %b want 0001", ack); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL single_err got %b want 0", err); end
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b0) begin nerr++; $display("FAIL single_busy_w_e got %b want 0", w_e); end
    clock();
    nvec++; if (ack !== 4'b0000) begin nerr++; $display("FAIL single_ack_drop got %b want 0000", ack); end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock();
  endtask

  task automatic test_all_req();
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'h100 + k;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      nvec++; if (w_e !== 1'b1 || gid !== IDW'(want[c]))
        begin nerr++; $display("FAIL rr_grant c%0d got w_e=%b id=%0d want 1/%0d", c, w_e, gid, want[c]); end
      nvec++; if (w_data !== 32'h100 + want[c])
        begin nerr++; $display("FAIL rr_data c%0d got %h want %h", c, w_data, 32'h100 + want[c]); end
      clock();
      nvec++; if (ack !== (N'(1) << want[c]))
        begin nerr++; $display("FAIL rr_ack c%0d got %b want %b", c, ack, N'(1) << want[c]); end
    end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rr_err got %b want 0", err); end
  endtask

  task automatic test_single_hold();
    logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      nvec++; if (w_e !== pat[c] || (pat[c] && gid !== 2'd2))
        begin nerr++; $display("FAIL hold_w_e c%0d got %b id=%0d want %b id=2", c, w_e, gid, pat[c]); end
      clock();
      nvec++; if (ack[2] !== pat[c]) begin nerr++; $display("FAIL hold_ack c%0d got %b want %b", c, ack[2], pat[c]); end
    end
  endtask

  task automatic test_full_fifo();
    logic we_want[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   id_want[5]  = '{1, 2, 0, 0, 0};
    do_reset();
    fifo_mode = 1'b1; depth = 2;
    for (int c = 0; c < 5; c++) begin
      drive(4'b0110, 1'b0, (c == 4), 1'b0, 1'b0);
      nvec++; if (w_e !== we_want[c] || gid !== IDW'(id_want[c]))
        begin nerr++; $display("FAIL full_c%0d got w_e=%b id=%0d want %b/%0d", c, w_e, gid, we_want[c], id_want[c]); end
      clock();
    end
    drive(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b1 || gid !== 2'd1)
      begin nerr++; $display("FAIL full_after_read got w_e=%b id=%0d want 1/1", w_e, gid); end
    clock();
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL full_err got %b want 0", err); end
    fifo_mode = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b0) begin nerr++; $display("FAIL flush_w_e got %b want 0", w_e); end
    clock();
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (w_e !== 1'b1 || gid !== 2'd3)
      begin nerr++; $display("FAIL flush_resume got w_e=%b id=%0d want 1/3", w_e, gid); end
    clock();
    drive(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    nvec++; if (ack !== 4'b1000) begin nerr++; $display("FAIL flush_late_ack got %b want 1000", ack); end
    clock();
    nvec++; if (ack !== 4'b0000 || err !== 1'b0)
      begin nerr++; $display("FAIL flush_clear got ack=%b err=%b want 0000/0", ack, err); end
  endtask

  task automatic test_err_sticky();
    do_reset();
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
    clock();
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL err_set got %b want 1", err); end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock();
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", err); end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    clock();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if (err !== 1'b0 || ack !== '0 || w_e !== 1'b0 || gid !== '0 || w_data !== '0)
      begin nerr++; $display("FAIL err_reset got err=%b ack=%b w_e=%b id=%0d data=%h want all 0", err, ack, w_e, gid, w_data); end
    clock();
  endtask

  task automatic test_random();
    logic [N-1:0] rq   = '0;
    logic [N-1:0] seen = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (seen[k]) begin
          seen[k] = 1'b0;
          rq[k] = 1'($urandom_range(0, 1));
          req_data[k*W +: W] = $urandom;
        end else if (!rq[k] && $urandom_range(0, 3) == 0) begin
          rq[k] = 1'b1;
          req_data[k*W +: W] = $urandom;
        end
        if (m_ack == k) seen[k] = 1'b1;
      end
      avail_bit = ($urandom_range(0, 3) != 0);
      drive(rq, ($urandom_range(0, 15) == 0), 1'b0, 1'b0, ($urandom_range(0, 63) == 0));
      nvec++; if (w_e !== (exp_k >= 0) || gid !== exp_gid() || w_data !== exp_data())
        begin nerr++; $display("FAIL rand_comb c%0d got w_e=%b id=%0d data=%h want %b/%0d/%h", c, w_e, gid, w_data, exp_k >= 0, exp_gid(), exp_data()); end
      clock();
      nvec++; if (ack !== exp_ackv() || err !== m_err)
        begin nerr++; $display("FAIL rand_reg c%0d got ack=%b err=%b want %b/%b", c, ack, err, exp_ackv(), m_err); end
    end
  endtask

  initial begin
    req = '0; req_data = '0; flush = 1'b0; rst = 1'b1; w_ack = 1'b0; w_avail = 1'b1;
    test_reset();
    test_single_write();
    test_all_req();
    test_single_hold();
    test_full_fifo();
    test_flush();
    test_err_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached with %0d vectors applied", nvec);
    $fatal(1, "watchdog");
  end

endmodule
